// File: rtl/qspi_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qspi_pad_ctrl
// Purpose  : QSPI pad controller between the core QSPI master and the chip
//            tri-state pad buffers. Registered pad outputs, chip-select
//            collision detection, a bus-turnaround guard before SIO is
//            re-driven, and a configurable SIO input sample delay.
// Options  : QSPI_PAD_LOOPBACK_EN adds a LOOPBACK input that feeds the input
//            sample chain from PAD_SIO_O and releases all SIO drivers.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_pad_ctrl #(
  parameter int NUM_CS      = 2,
  parameter int SIO_WIDTH   = 4,
  parameter int TURN_CYCLES = 2,
  parameter int SAMPLE_DLY  = 1
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 ENABLE,
`ifdef QSPI_PAD_LOOPBACK_EN
  input  logic                 LOOPBACK,
`endif
  input  logic [NUM_CS-1:0]    CORE_CS_N,
  input  logic                 CORE_SCK,
  input  logic [SIO_WIDTH-1:0] CORE_SIO_O,
  input  logic [SIO_WIDTH-1:0] CORE_SIO_E,
  output logic [SIO_WIDTH-1:0] CORE_SIO_I,
  output logic [NUM_CS-1:0]    PAD_CS_N_O,
  output logic                 PAD_CS_N_E,
  output logic                 PAD_SCK_O,
  output logic                 PAD_SCK_E,
  output logic [SIO_WIDTH-1:0] PAD_SIO_O,
  output logic [SIO_WIDTH-1:0] PAD_SIO_E,
  input  logic [SIO_WIDTH-1:0] PAD_SIO_I,
  output logic                 TURN_ACTIVE,
  output logic                 CS_ERR
);

  // Counter reload: the guard spends TURN_CYCLES cycles in TURN.
  localparam logic [3:0] c_turn_load = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_HIZ   = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_CS-1:0]      pad_cs_n_q;
  logic                   pad_cs_n_e_q;
  logic                   pad_sck_q;
  logic                   pad_sck_e_q;
  logic [SIO_WIDTH-1:0]   pad_sio_o_q;
  logic [SIO_WIDTH-1:0]   pad_sio_e_q, pad_sio_e_d;
  logic                   cs_err_q;

  logic                   w_any_e;
  logic                   w_loopback;
  logic [NUM_CS-1:0]      w_cs_low;
  logic                   w_cs_multi;
  logic [SIO_WIDTH-1:0]   w_sio_src;

`ifdef QSPI_PAD_LOOPBACK_EN
  assign w_loopback = LOOPBACK;
`else
  assign w_loopback = 1'b0;
`endif

  assign w_any_e    = |CORE_SIO_E;
  // x & (x-1) clears the lowest set bit: non-zero means two or more selects low.
  assign w_cs_low   = ~CORE_CS_N;
  assign w_cs_multi = |(w_cs_low & (w_cs_low - NUM_CS'(1)));

  // SIO direction next-state, guard counter and next drive enables.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pad_sio_e_d = '0;
    if (!ENABLE) begin
      state_d = ST_HIZ;
    end else begin
      case (state_q)
        ST_HIZ: begin
          if (w_any_e) begin
            if (TURN_CYCLES > 0) begin
              state_d = ST_TURN;
              cnt_d   = c_turn_load;
            end else begin
              state_d = ST_DRIVE;
            end
          end
        end
        ST_TURN: begin
          if (!w_any_e) begin
            state_d = ST_HIZ;
          end else if (cnt_q == 4'd0) begin
            state_d = ST_DRIVE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_DRIVE: begin
          if (!w_any_e) begin
            state_d = ST_HIZ;
          end
        end
        default: state_d = ST_HIZ;
      endcase
    end
    // Drive enables follow the state being entered, so release is immediate.
    if (state_d == ST_DRIVE && !w_loopback) begin
      pad_sio_e_d = CORE_SIO_E;
    end
  end

  // FSM state, guard counter and all registered pad outputs.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q      <= ST_HIZ;
      cnt_q        <= 4'd0;
      pad_cs_n_q   <= '1;
      pad_cs_n_e_q <= 1'b0;
      pad_sck_q    <= 1'b0;
      pad_sck_e_q  <= 1'b0;
      pad_sio_o_q  <= '0;
      pad_sio_e_q  <= '0;
      cs_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pad_cs_n_q   <= w_cs_multi ? '1 : CORE_CS_N;
      pad_cs_n_e_q <= ENABLE;
      pad_sck_q    <= CORE_SCK;
      pad_sck_e_q  <= ENABLE;
      pad_sio_o_q  <= CORE_SIO_O;
      pad_sio_e_q  <= pad_sio_e_d;
      cs_err_q     <= cs_err_q | w_cs_multi;
    end
  end

  assign w_sio_src = w_loopback ? pad_sio_o_q : PAD_SIO_I;

  generate
    if (SAMPLE_DLY == 0) begin : g_dly_none
      assign CORE_SIO_I = w_sio_src;
    end else begin : g_dly_chain
      logic [SIO_WIDTH-1:0] dly_q [SAMPLE_DLY];
      // Input sample shift chain, independent of the direction FSM.
      always_ff @(posedge CLK) begin
        if (RES) begin
          for (int i = 0; i < SAMPLE_DLY; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= w_sio_src;
          for (int i = SAMPLE_DLY - 1; i > 0; i--) dly_q[i] <= dly_q[i-1];
        end
      end
      assign CORE_SIO_I = dly_q[SAMPLE_DLY-1];
    end
  endgenerate

  assign PAD_CS_N_O  = pad_cs_n_q;
  assign PAD_CS_N_E  = pad_cs_n_e_q;
  assign PAD_SCK_O   = pad_sck_q;
  assign PAD_SCK_E   = pad_sck_e_q;
  assign PAD_SIO_O   = pad_sio_o_q;
  assign PAD_SIO_E   = pad_sio_e_q;
  assign TURN_ACTIVE = (state_q == ST_TURN);
  assign CS_ERR      = cs_err_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_pad_ctrl
// Purpose  : Self-checking bench for qspi_pad_ctrl (default parameters).
//            Directed literal checks followed by randomized traffic compared
//            every cycle against a run-length behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_pad_ctrl;

  localparam int NCS = 2;
  localparam int SW  = 4;
  localparam int T   = 2;

  logic          CLK = 1'b0;
  logic          RES = 1'b1;
  logic          ENABLE = 1'b1;
  logic [NCS-1:0] CORE_CS_N = '1;
  logic          CORE_SCK = 1'b0;
  logic [SW-1:0] CORE_SIO_O = '0;
  logic [SW-1:0] CORE_SIO_E = '0;
  logic [SW-1:0] CORE_SIO_I;
  logic [NCS-1:0] PAD_CS_N_O;
  logic          PAD_CS_N_E;
  logic          PAD_SCK_O;
  logic          PAD_SCK_E;
  logic [SW-1:0] PAD_SIO_O;
  logic [SW-1:0] PAD_SIO_E;
  logic [SW-1:0] PAD_SIO_I = '0;
  logic          TURN_ACTIVE;
  logic          CS_ERR;

  int checks = 0;
  int errors = 0;

  qspi_pad_ctrl #(.NUM_CS(NCS), .SIO_WIDTH(SW), .TURN_CYCLES(T), .SAMPLE_DLY(1)) dut (
    .CLK(CLK), .RES(RES), .ENABLE(ENABLE),
`ifdef QSPI_PAD_LOOPBACK_EN
    .LOOPBACK(1'b0),
`endif
    .CORE_CS_N(CORE_CS_N), .CORE_SCK(CORE_SCK), .CORE_SIO_O(CORE_SIO_O),
    .CORE_SIO_E(CORE_SIO_E), .CORE_SIO_I(CORE_SIO_I),
    .PAD_CS_N_O(PAD_CS_N_O), .PAD_CS_N_E(PAD_CS_N_E),
    .PAD_SCK_O(PAD_SCK_O), .PAD_SCK_E(PAD_SCK_E),
    .PAD_SIO_O(PAD_SIO_O), .PAD_SIO_E(PAD_SIO_E), .PAD_SIO_I(PAD_SIO_I),
    .TURN_ACTIVE(TURN_ACTIVE), .CS_ERR(CS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: m_run counts consecutive sampled cycles with ENABLE
  // high and a drive request pending. The bus is in guard while
  // 1 <= m_run <= T and driven once m_run exceeds T.
  int             m_run = 0;
  logic [NCS-1:0] m_cs = '1;
  logic           m_err = 1'b0;
  logic           m_en = 1'b0;
  logic           m_sck = 1'b0;
  logic [SW-1:0]  m_sio_o = '0;
  logic [SW-1:0]  m_sio_e = '0;
  logic [SW-1:0]  m_sio_i = '0;
  bit             m_valid = 1'b0;

  always @(posedge CLK) begin
    if (RES) begin
      m_run   <= 0;
      m_cs    <= '1;
      m_err   <= 1'b0;
      m_en    <= 1'b0;
      m_sck   <= 1'b0;
      m_sio_o <= '0;
      m_sio_e <= '0;
      m_sio_i <= '0;
    end else begin
      m_cs    <= ($countones(~CORE_CS_N) > 1) ? '1 : CORE_CS_N;
      m_err   <= m_err | ($countones(~CORE_CS_N) > 1);
      m_en    <= ENABLE;
      m_sck   <= CORE_SCK;
      m_sio_o <= CORE_SIO_O;
      m_sio_e <= CORE_SIO_E;
      m_sio_i <= PAD_SIO_I;
      if (ENABLE && (CORE_SIO_E != '0)) m_run <= (m_run < 1000) ? m_run + 1 : m_run;
      else                               m_run <= 0;
    end
    m_valid <= 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      chk("cs_n_o",  32'(PAD_CS_N_O),  32'(m_cs));
      chk("cs_n_e",  32'(PAD_CS_N_E),  32'(m_en));
      chk("sck_o",   32'(PAD_SCK_O),   32'(m_sck));
      chk("sck_e",   32'(PAD_SCK_E),   32'(m_en));
      chk("sio_o",   32'(PAD_SIO_O),   32'(m_sio_o));
      chk("sio_e",   32'(PAD_SIO_E),   32'((m_run > T) ? m_sio_e : 4'h0));
      chk("turn",    32'(TURN_ACTIVE), 32'((m_run >= 1) && (m_run <= T)));
      chk("cs_err",  32'(CS_ERR),      32'(m_err));
      chk("sio_i",   32'(CORE_SIO_I),  32'(m_sio_i));
    end
  end

  // Advance one clock; inputs may then be changed safely.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    // Reset held for three cycles with ENABLE high.
    RES = 1'b1; ENABLE = 1'b1;
    repeat (3) tick();
    chk("rst_cs_n",   32'(PAD_CS_N_O), 32'h3);
    chk("rst_sio_e",  32'(PAD_SIO_E),  32'h0);
    chk("rst_cs_e",   32'(PAD_CS_N_E), 32'h0);
    chk("rst_sck_e",  32'(PAD_SCK_E),  32'h0);
    chk("rst_cs_err", 32'(CS_ERR),     32'h0);
    RES = 1'b0;
    tick();
    chk("cs_e_after_rst", 32'(PAD_CS_N_E), 32'h1);

    // Turnaround guard.
    CORE_SIO_O = 4'hA; CORE_SIO_E = 4'hF; CORE_SCK = 1'b1;
    tick();
    chk("guard_t1_turn", 32'(TURN_ACTIVE), 32'h1);
    chk("guard_t1_e",    32'(PAD_SIO_E),   32'h0);
    chk("sck_follow",    32'(PAD_SCK_O),   32'h1);
    tick();
    chk("guard_t2_turn", 32'(TURN_ACTIVE), 32'h1);
    chk("guard_t2_e",    32'(PAD_SIO_E),   32'h0);
    tick();
    chk("guard_t3_e",    32'(PAD_SIO_E),   32'hF);
    chk("guard_t3_o",    32'(PAD_SIO_O),   32'hA);
    chk("guard_t3_turn", 32'(TURN_ACTIVE), 32'h0);
    CORE_SIO_E = 4'h3;
    tick();
    chk("pattern_change", 32'(PAD_SIO_E), 32'h3);

    // Fast release.
    CORE_SIO_E = 4'h0;
    tick();
    chk("release_e",    32'(PAD_SIO_E),   32'h0);
    chk("release_turn", 32'(TURN_ACTIVE), 32'h0);

    // Guard abandoned.
    CORE_SIO_E = 4'h1;
    tick();
    chk("abandon_turn", 32'(TURN_ACTIVE), 32'h1);
    CORE_SIO_E = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abandon_e",    32'(PAD_SIO_E),   32'h0);
      chk("abandon_turn_off", 32'(TURN_ACTIVE), 32'h0);
    end

    // Chip-select collision.
    CORE_CS_N = 2'b00;
    tick();
    chk("coll_cs_n", 32'(PAD_CS_N_O), 32'h3);
    chk("coll_err",  32'(CS_ERR),     32'h1);
    CORE_CS_N = 2'b10;
    tick();
    chk("post_coll_cs_n", 32'(PAD_CS_N_O), 32'h2);
    chk("post_coll_err",  32'(CS_ERR),     32'h1);

    // Input delay.
    PAD_SIO_I = 4'h5;
    tick();
    chk("sio_i_dly", 32'(CORE_SIO_I), 32'h5);

    // ENABLE dropped while driving, then a fresh guard.
    CORE_SIO_E = 4'hF;
    repeat (3) tick();
    chk("drive_before_dis", 32'(PAD_SIO_E), 32'hF);
    ENABLE = 1'b0;
    tick();
    chk("dis_sio_e", 32'(PAD_SIO_E),  32'h0);
    chk("dis_cs_e",  32'(PAD_CS_N_E), 32'h0);
    chk("dis_sck_e", 32'(PAD_SCK_E),  32'h0);
    ENABLE = 1'b1;
    tick();
    chk("reen_turn", 32'(TURN_ACTIVE), 32'h1);
    chk("reen_e",    32'(PAD_SIO_E),   32'h0);

    // Randomized traffic; the every-cycle compare checks it.
    for (int n = 0; n < 3000; n++) begin
      RES    = ($urandom_range(0, 199) == 0);
      ENABLE = ($urandom_range(0, 99) < 94);
      if ($urandom_range(0, 99) < 18) begin
        if ($urandom_range(0, 2) == 0) CORE_SIO_E = 4'h0;
        else                           CORE_SIO_E = 4'($urandom_range(1, 15));
      end
      case ($urandom_range(0, 19))
        0:       CORE_CS_N = 2'b00;
        1, 2, 3: CORE_CS_N = 2'b10;
        4, 5, 6: CORE_CS_N = 2'b01;
        default: CORE_CS_N = 2'b11;
      endcase
      CORE_SCK   = 1'($urandom_range(0, 1));
      CORE_SIO_O = 4'($urandom_range(0, 15));
      PAD_SIO_I  = 4'($urandom_range(0, 15));
      tick();
    end

    // Sticky error clears only on reset.
    CORE_CS_N = 2'b00; RES = 1'b0; ENABLE = 1'b1;
    tick();
    chk("err_set_again", 32'(CS_ERR), 32'h1);
    CORE_CS_N = 2'b11; RES = 1'b1;
    tick();
    chk("err_cleared", 32'(CS_ERR),     32'h0);
    chk("rst_cs_n_end", 32'(PAD_CS_N_O), 32'h3);
    RES = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
